// File: rtl/seq_mult_8x8.sv
// seq_mult_8x8: sequential 8x8 shift-and-add multiplier feeding the
// 4-digit hex display. One multiplier bit is consumed per RUN cycle, LSB
// first; the 16-bit product is written to mult_result on the edge that
// enters DONE and held there until the next completion.
//
// Build option: define SIGNED_MULT_EN to treat both operands as two's
// complement (magnitudes are multiplied, sign applied at completion).
// Without it the block is purely unsigned and no sign logic exists.
module seq_mult_8x8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  operand_a,
  input  logic [7:0]  operand_b,
  output logic [15:0] mult_result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  mcand_q;
  logic [7:0]  mplier_q;
  logic [15:0] acc_q;
  logic [3:0]  count_q;
  logic [15:0] result_q;
  logic        busy_q;
  logic        done_q;
`ifdef SIGNED_MULT_EN
  logic        sign_q;
`endif

  logic [7:0]  mag_a_d;
  logic [7:0]  mag_b_d;
  logic [15:0] addend_d;
  logic [15:0] acc_d;
  logic [15:0] final_d;

  // Operand magnitudes at acceptance, next accumulator value and final product.
  // An 8-bit magnitude holds 128 exactly, so -128 needs no special case.
  always_comb begin
`ifdef SIGNED_MULT_EN
    mag_a_d = operand_a[7] ? (~operand_a + 8'd1) : operand_a;
    mag_b_d = operand_b[7] ? (~operand_b + 8'd1) : operand_b;
`else
    mag_a_d = operand_a;
    mag_b_d = operand_b;
`endif
    addend_d = {8'h00, mcand_q} << count_q;
    acc_d    = acc_q + (mplier_q[0] ? addend_d : 16'h0000);
`ifdef SIGNED_MULT_EN
    // Negating a zero product yields zero, so no special case is needed.
    final_d  = sign_q ? (~acc_d + 16'd1) : acc_d;
`else
    final_d  = acc_d;
`endif
  end

  // Control FSM with registered busy/done and the shift-and-add datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= 8'h00;
      mplier_q <= 8'h00;
      acc_q    <= 16'h0000;
      count_q  <= 4'd0;
      result_q <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SIGNED_MULT_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        // DONE accepts a new request exactly like IDLE (back-to-back operation).
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= mag_a_d;
            mplier_q <= mag_b_d;
            acc_q    <= 16'h0000;
            count_q  <= 4'd0;
`ifdef SIGNED_MULT_EN
            sign_q   <= operand_a[7] ^ operand_b[7];
`endif
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 4'd1;
          // Eighth RUN edge: publish the product and pulse done.
          if (count_q == 4'd7) begin
            result_q <= final_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mult_result = result_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_mult_8x8.sv
// Testbench for seq_mult_8x8. Expected products are queued when a request
// is driven; a monitor pops and compares them whenever done is observed.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge (monitor) or on the falling edge (directed checks).
module tb_seq_mult_8x8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic [15:0] mult_result;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  seq_mult_8x8 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .mult_result (mult_result),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference product using native integer multiplication.
  function automatic logic [15:0] exp_prod(input logic [7:0] a, input logic [7:0] b);
    int pa;
    int pb;
`ifdef SIGNED_MULT_EN
    pa = int'($signed(a));
    pb = int'($signed(b));
`else
    pa = int'(a);
    pb = int'(b);
`endif
    return 16'(pa * pb);
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest queued product.
  always @(posedge clk) begin
    #1;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("result", {16'b0, mult_result}, {16'b0, mon_exp});
      end
    end
  end

  // Drive one request; returns at the falling edge just after acceptance.
  task automatic accept_op(input logic [7:0] a, input logic [7:0] b, input bit push);
    @(negedge clk);
    start     = 1'b1;
    operand_a = a;
    operand_b = b;
    if (push) exp_q.push_back(exp_prod(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full transaction with busy/done handshake timing checks.
  task automatic do_mult(input logic [7:0] a, input logic [7:0] b);
    accept_op(a, b, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check_eq("busy_run", {31'b0, busy}, 32'd1);
      check_eq("done_run", {31'b0, done}, 32'd0);
      @(negedge clk);
    end
    check_eq("done_pulse", {31'b0, done}, 32'd1);
    check_eq("busy_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check_eq("done_drop", {31'b0, done}, 32'd0);
    $display("mult a=0x%02h b=0x%02h -> 0x%04h (expected 0x%04h)", a, b, mult_result, exp_prod(a, b));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    operand_a = 8'h00;
    operand_b = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_result", {16'b0, mult_result}, 32'h0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;

    // Basic product, then held through idle cycles.
    do_mult(8'h0C, 8'h0D);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("hold_result", {16'b0, mult_result}, {16'b0, exp_prod(8'h0C, 8'h0D)});
    end

    // Boundary operands.
    do_mult(8'hFF, 8'hFF);
    do_mult(8'h00, 8'hA5);
    do_mult(8'h01, 8'h80);

    // start held high: done every 9 cycles, busy low only in DONE.
    @(negedge clk);
    start = 1'b1;
    operand_a = 8'h03;
    operand_b = 8'h05;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_prod(8'h03, 8'h05));
    for (int j = 0; j <= 35; j++) begin
      @(negedge clk);
      check_eq("bb_done", {31'b0, done}, (j % 9 == 8) ? 32'd1 : 32'd0);
      check_eq("bb_busy", {31'b0, busy}, (j % 9 == 8) ? 32'd0 : 32'd1);
      if (j == 35) start = 1'b0;
    end
    $display("back-to-back: 4 products of 0x03*0x05 observed");
    repeat (3) @(negedge clk);

    // A start pulse during RUN is ignored.
    accept_op(8'h03, 8'h05, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    operand_a = 8'h11;
    operand_b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("ign_done", {31'b0, done}, 32'd1);
    check_eq("ign_result", {16'b0, mult_result}, {16'b0, exp_prod(8'h03, 8'h05)});
    $display("ignored start during RUN -> 0x%04h", mult_result);
    repeat (12) @(negedge clk);

    // Reset in the middle of a run abandons it.
    accept_op(8'h0C, 8'h0D, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_done", {31'b0, done}, 32'd0);
    check_eq("abort_result", {16'b0, mult_result}, 32'h0);
    $display("reset during RUN -> result 0x%04h", mult_result);
    repeat (12) @(negedge clk);
    do_mult(8'h02, 8'h03);

`ifdef SIGNED_MULT_EN
    do_mult(8'hFF, 8'h02);
    do_mult(8'h80, 8'h80);
    do_mult(8'h80, 8'h01);
    do_mult(8'h00, 8'h80);
    do_mult(8'h7F, 8'h81);
`endif

    // A few random operands.
    for (int i = 0; i < 6; i++) begin
      do_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
